// File: rtl/fifo_rd_arbiter_if.sv
// Handshake bundle between the FIFO read arbiter, its channel FIFOs and the
// downstream consumer.
//
// Valid/ready semantics: a word transfers on every rd_clk edge where
// out_valid and out_ready are both high; once out_valid is raised, out_data,
// out_src and out_first hold until that transfer happens. On the FIFO side,
// a first-word-fall-through head word is valid whenever fifo_empty[i] is low,
// and a high fifo_rd_en[i] at an edge consumes that word.
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = 2
);
  logic [NUM_REQ-1:0]            fifo_empty;
  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_rd_data;
  logic [NUM_REQ-1:0]            fifo_rd_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          out_first;

  // Arbiter side: reads the FIFO heads, pops them, drives the output word.
  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data,
    output out_src,
    output out_first
  );

  // Environment side: the FIFO read ports and the consumer.
  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    input  out_src,
    input  out_first
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler for NUM_REQ first-word-fall-through FIFOs.
// One FIFO is granted at a time and drained for up to BURST_MAX beats; the
// popped words leave through a single registered valid/ready stage tagged
// with their source index and a first-beat-of-grant flag.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 8,
  parameter int SRC_W      = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rstn,
  fifo_rd_arbiter_if.master    bus,
  input  logic [NUM_REQ-1:0]   req_enable,
  output logic                 busy,
  output logic                 dbg_state,
  output logic [SRC_W-1:0]     dbg_last_grant
);

  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam int PAD_N = 1 << SRC_W;
  localparam logic [SRC_W:0]     NUM_REQ_X = (SRC_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_MAX - 1);
  localparam logic [SRC_W-1:0]   LAST_IDX  = SRC_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  logic [SRC_W-1:0]      g;
  logic [SRC_W-1:0]      last_grant;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]      out_src_q;
  logic                  out_first_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [PAD_N-1:0]      elig_pad;
  logic                  sel_valid;
  logic [SRC_W-1:0]      sel_idx;
  logic [SRC_W:0]        cand;

  logic                  g_empty;
  logic                  g_en;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  pop;
  logic                  last_beat;
  logic                  grant_end;
  logic [NUM_REQ-1:0]    rd_en;

  // A requester competes only when enabled and holding a word. The vector is
  // zero-padded so any SRC_W-bit index addresses it without a range check.
  assign eligible = req_enable & ~bus.fifo_empty;
  assign elig_pad = PAD_N'(eligible);

  // Round-robin pick: scan from the farthest offset down to last_grant+1 so
  // the nearest eligible requester after the previous grant wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (SRC_W+1)'(k);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (elig_pad[cand[SRC_W-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Mux out the empty flag, enable and head word of the granted FIFO.
  always_comb begin
    g_empty = 1'b1;
    g_en    = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == SRC_W'(i)) begin
        g_empty = bus.fifo_empty[i];
        g_en    = req_enable[i];
        g_data  = bus.fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pop whenever the granted FIFO has a word, is still enabled and the
  // output register is free or being emptied this same cycle. A grant ends
  // after its BURST_MAX-th pop, or at once when its FIFO runs dry or is
  // disabled; a stalled consumer only pauses it.
  assign pop       = (state == GRANT) & ~g_empty & g_en & (~out_valid_q | bus.out_ready);
  assign last_beat = pop & (beat_cnt == LAST_BEAT);
  assign grant_end = (state == GRANT) & (last_beat | g_empty | ~g_en);

  // Pop strobe goes only to the granted FIFO, so it is one-hot or zero.
  always_comb begin
    rd_en = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_en[i] = pop & (g == SRC_W'(i));
    end
  end

  // Grant FSM plus the output register; everything here clears on rd_rstn,
  // which discards a word that was popped but not yet accepted.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      g           <= '0;
      last_grant  <= LAST_IDX;
      beat_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_first_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            g        <= sel_idx;
            beat_cnt <= '0;
            state    <= GRANT;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (pop) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (grant_end) begin
            last_grant <= g;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A pop overwrites the output word even while the old one is being
      // accepted, which keeps a grant streaming at one beat per cycle.
      if (pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= g_data;
        out_src_q   <= g;
        out_first_q <= (beat_cnt == '0);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_first  = out_first_q;

  assign dbg_state      = logic'(state);
  assign dbg_last_grant = last_grant;

endmodule
